// File: rtl/uart_pkg.sv
// Shared UART types and constants. With UART_RX_PARITY_EN defined, the receiver
// state set includes the even-parity state.
package uart_pkg;

  localparam int unsigned CLK_CNT_W = 16;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous idle-high input; both stages reset to 1
// so that releasing reset never looks like a falling edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start validation, mid-bit sampling, framing/overrun detection
// and a valid/ready byte output. Define UART_RX_PARITY_EN to check even parity.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err,
  output logic              busy
);

  localparam logic [CLK_CNT_W-1:0] LP_HALF = CLK_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CLK_CNT_W-1:0] LP_FULL = CLK_CNT_W'(CLKS_PER_BIT - 1);

  logic                 w_rx_s;
  rx_state_t            r_state;
  logic [CLK_CNT_W-1:0] r_clk_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_W-1:0]    r_shift;
  logic [DATA_W-1:0]    r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_oerr;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_perr;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_oerr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_ferr <= 1'b0;
      r_oerr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      // Consumption first; a delivery later in this block overrides the clear.
      if (r_valid && data_ready) r_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state   <= ST_START;
            r_clk_cnt <= '0;
          end
        end
        ST_START: begin
          if (r_clk_cnt == LP_HALF) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (r_clk_cnt == LP_FULL) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_cnt] <= w_rx_s;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (r_clk_cnt == LP_FULL) begin
            r_clk_cnt <= '0;
            r_par_bad <= even_parity(r_shift) ^ w_rx_s;
            r_state   <= ST_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (r_clk_cnt == LP_FULL) begin
            r_clk_cnt <= '0;
            if (!w_rx_s) begin
              r_ferr  <= 1'b1;
              r_state <= ST_WAIT_IDLE;
            end else begin
              r_state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                r_perr <= 1'b1;
              end else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_oerr  <= r_valid && !data_ready;
              end
`else
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_oerr  <= r_valid && !data_ready;
`endif
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign frame_err   = r_ferr;
  assign overrun_err = r_oerr;
  assign busy        = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_perr;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: frames are scheduled as timed outcome events; a per-cycle
// compare checks every output against the resulting expected state.
module tb_uart_rx_frame;

  localparam int unsigned CPB   = 16;
  localparam int unsigned H     = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NB    = 11;
`else
  localparam int unsigned NB    = 10;
`endif
  localparam int unsigned NEVER = 32'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err, overrun_err, busy;

  uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_DELIVER, EV_FERR, EV_PERR} ev_kind_t;
  typedef struct {
    int unsigned edge_n;
    ev_kind_t    kind;
    logic [7:0]  b;
  } ev_t;

  ev_t         ev_q[$];
  int unsigned ev_rd = 0;
  int unsigned cyc   = 0;
  int unsigned bfrom = NEVER;
  int unsigned bto   = 0;
  logic [7:0]  m_data  = 8'h00;
  logic        m_valid = 1'b0;
  logic        m_ferr  = 1'b0;
  logic        m_perr  = 1'b0;
  logic        m_ovr   = 1'b0;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
  endtask

  // Model: outcome of each frame lands on the edge it is scheduled for.
  always @(posedge clk) begin : model
    logic was_valid;
    cyc = cyc + 1;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    m_ovr  = 1'b0;
    if (!rst_n) begin
      m_data  = 8'h00;
      m_valid = 1'b0;
    end else begin
      was_valid = m_valid;
      if (was_valid && data_ready) m_valid = 1'b0;
      if (ev_rd < ev_q.size() && ev_q[ev_rd].edge_n == cyc) begin
        case (ev_q[ev_rd].kind)
          EV_DELIVER: begin
            m_ovr   = was_valid && !data_ready;
            m_data  = ev_q[ev_rd].b;
            m_valid = 1'b1;
          end
          EV_FERR: m_ferr = 1'b1;
          default: m_perr = 1'b1;
        endcase
        ev_rd++;
      end
    end
  end

  always @(negedge clk) begin
    chk("data_valid",  data_valid,  rst_n ? m_valid : 1'b0);
    chk("data_out",    data_out,    rst_n ? m_data  : 8'h00);
    chk("frame_err",   frame_err,   rst_n ? m_ferr  : 1'b0);
    chk("parity_err",  parity_err,  rst_n ? m_perr  : 1'b0);
    chk("overrun_err", overrun_err, rst_n ? m_ovr   : 1'b0);
    chk("busy",        busy,        (rst_n && cyc >= bfrom && cyc < bto) ? 1'b1 : 1'b0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input int unsigned n);
    while (cyc < n) step();
  endtask

  task automatic hold(input logic v);
    rx = v;
    repeat (CPB) step();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    bfrom = NEVER;
    bto   = 0;
  endtask

  // Drives a frame up to the start of its stop bit; returns stop-sample edge and frame end edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_ok,
                            output int unsigned s_edge, output int unsigned end_edge);
    ev_t ev;
    int unsigned e;
    e        = cyc;
    s_edge   = e + 3 + H + (NB - 1) * CPB;
    end_edge = e + NB * CPB;
    ev.edge_n = s_edge;
    ev.b      = b;
    ev.kind   = !stop_bit ? EV_FERR : (!par_ok ? EV_PERR : EV_DELIVER);
    ev_q.push_back(ev);
    bfrom = e + 3;
    bto   = stop_bit ? s_edge : NEVER;
    hold(1'b0);
    for (int i = 0; i < 8; i++) hold(b[i]);
`ifdef UART_RX_PARITY_EN
    hold((^b) ^ ~par_ok);
`endif
    rx = stop_bit;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned s, en, g, e;
    logic [7:0] b;

    assert_reset();
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset data_valid", data_valid, 1'b0);
    chk("reset data_out", data_out, 8'h00);
    chk("reset busy", busy, 1'b0);
    repeat (10) step();

    // Single frame with handshake
    send_frame(8'h37, 1'b1, 1'b1, s, en);
    wait_edge(s - 1);
    @(negedge clk);
    chk("t1 valid before stop", data_valid, 1'b0);
    wait_edge(s);
    @(negedge clk);
    chk("t1 valid", data_valid, 1'b1);
    chk("t1 data", data_out, 8'h37);
    data_ready = 1'b1;
    @(negedge clk);
    chk("t1 valid cleared", data_valid, 1'b0);
    data_ready = 1'b0;
    wait_edge(en);
    repeat (5) step();

    // Back-to-back frames, consumer stalled
    send_frame(8'h37, 1'b1, 1'b1, s, en);
    wait_edge(en);
    send_frame(8'h49, 1'b1, 1'b1, s, en);
    wait_edge(s);
    @(negedge clk);
    chk("ovr pulse", overrun_err, 1'b1);
    chk("ovr data", data_out, 8'h49);
    chk("ovr valid", data_valid, 1'b1);
    @(negedge clk);
    chk("ovr single pulse", overrun_err, 1'b0);
    wait_edge(en);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    repeat (5) step();

    // 3-cycle glitch on idle line
    g = cyc;
    bfrom = g + 3;
    bto   = g + 3 + H;
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    wait_edge(g + 5);
    @(negedge clk);
    chk("glitch busy mid", busy, 1'b1);
    repeat (20) step();
    @(negedge clk);
    chk("glitch busy after", busy, 1'b0);
    chk("glitch no valid", data_valid, 1'b0);

    // Stop bit low, line held low
    send_frame(8'h55, 1'b0, 1'b1, s, en);
    wait_edge(s);
    @(negedge clk);
    chk("ferr pulse", frame_err, 1'b1);
    chk("ferr no valid", data_valid, 1'b0);
    wait_edge(en + 39);
    @(negedge clk);
    chk("ferr busy while low", busy, 1'b1);
    step();
    rx  = 1'b1;
    bto = cyc + 3;
    repeat (10) step();
    @(negedge clk);
    chk("ferr busy released", busy, 1'b0);
    repeat (5) step();

`ifdef UART_RX_PARITY_EN
    data_ready = 1'b1;
    send_frame(8'h49, 1'b1, 1'b0, s, en);
    wait_edge(s);
    @(negedge clk);
    chk("perr pulse", parity_err, 1'b1);
    chk("perr no valid", data_valid, 1'b0);
    wait_edge(en);
    send_frame(8'h49, 1'b1, 1'b1, s, en);
    wait_edge(s);
    @(negedge clk);
    chk("par ok valid", data_valid, 1'b1);
    chk("par ok data", data_out, 8'h49);
    wait_edge(en);
    data_ready = 1'b0;
    repeat (5) step();
`endif

    // Reset during bit 4 of a frame
    b = 8'h5A;
    e = cyc;
    bfrom = e + 3;
    bto   = NEVER;
    hold(1'b0);
    for (int i = 0; i < 4; i++) hold(b[i]);
    rx = b[4];
    repeat (8) step();
    @(negedge clk);
    chk("midframe busy", busy, 1'b1);
    step();
    assert_reset();
    @(negedge clk);
    chk("midreset data_out", data_out, 8'h00);
    chk("midreset busy", busy, 1'b0);
    chk("midreset valid", data_valid, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    data_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, s, en);
    wait_edge(s);
    @(negedge clk);
    chk("post reset valid", data_valid, 1'b1);
    chk("post reset data", data_out, 8'hA5);
    wait_edge(en);
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Receive end of the UART serial link: recovers 8-bit frames from the asynchronous `rx` line (idle high, 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit) and presents them on a valid/ready byte interface. It sits between the pad-side `rx` wire driven by a peer `uart` transmitter and the byte consumer. It replaces free-running frame capture with start-bit validation, mid-bit sampling, framing/overrun detection and flow control.

## Interface
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; legal range 4..65535.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx`  in  1  serial input, asynchronous to `clk`, idle high.
- `data_out`  out  8  last received byte; reset 8'h00.
- `data_valid`  out  1  `data_out` holds an unconsumed byte; reset 0.
- `data_ready`  in  1  consumer accepts `data_out` when `data_valid && data_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low; reset 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (0 when parity compiled out); reset 0.
- `overrun_err`  out  1  one-cycle pulse: good frame completed while previous byte unconsumed; reset 0.
- `busy`  out  1  FSM not in IDLE; reset 0.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1); FSM uses synchronized `rx_s` only.
- Bit counter `bit_cnt` (3 bits), cycle counter `clk_cnt` (16 bits, width from package constant).
- States: IDLE, START, DATA, PARITY (only with macro), STOP, WAIT_IDLE.
- IDLE: `rx_s==0` -> START, `clk_cnt<=0`.
- START: at `clk_cnt == CLKS_PER_BIT/2 - 1` (integer floor) sample `rx_s`; 0 -> DATA, `clk_cnt<=0`, `bit_cnt<=0`; 1 -> IDLE (glitch rejected, no error).
- DATA: at `clk_cnt == CLKS_PER_BIT-1` sample into shift register bit `bit_cnt`, `clk_cnt<=0`; after bit 7 -> PARITY or STOP.
- PARITY: at `clk_cnt == CLKS_PER_BIT-1` sample; error if XOR(data, sampled bit) != 0 -> STOP.
- STOP: at `clk_cnt == CLKS_PER_BIT-1` sample `rx_s`:
  - 1 and no parity error: deliver byte, -> IDLE.
  - 1 with parity error: `parity_err` pulse, byte discarded, -> IDLE.
  - 0: `frame_err` pulse, byte discarded, -> WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s==1` (break/line-low), then -> IDLE.
- Delivery: `data_out<=byte`, `data_valid<=1`. If `data_valid` was 1 and `data_ready` 0 that cycle: overwrite, keep valid, pulse `overrun_err`.
- `data_valid` clears the cycle after `data_valid && data_ready` unless a delivery coincides.
- Simultaneous handshake and delivery: old byte consumed, new byte loaded, `data_valid` stays 1, no overrun.

## Timing
- t0 = first cycle FSM sees `rx_s==0` in IDLE (2 cycles after pin edge).
- Start sample at t0+CLKS_PER_BIT/2; data bit k at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
- Stop sample at t0+CLKS_PER_BIT/2+9·CLKS_PER_BIT (+CLKS_PER_BIT with parity); `data_valid`/error pulses rise 1 cycle later.
- `busy` deasserts the cycle after the stop sample (or after WAIT_IDLE exit); a new start bit is accepted immediately.
- Reset mid-frame: all outputs to reset values immediately, FSM IDLE, partial byte lost; synchronizer at 1 so no false start on release.

## Configuration
- `UART_RX_PARITY_EN`: defined -> PARITY state present, even parity checked, frame is 11 bits. Undefined -> no PARITY state, `parity_err` tied 0, frame is 10 bits. Must match the peer transmitter build.

## Structure
- Package `uart_pkg`: state enum type, `CLK_CNT_W` (16), `DATA_W` (8), parity helper function.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with async reset to 1, shared later by other async inputs.

## Test plan
- CLKS_PER_BIT=16, send 8'h37 with good stop -> `data_out==8'h37`, `data_valid` 1 cycle after stop sample, `data_ready=1` clears it next cycle.
- Back-to-back 8'h37 then 8'h49, `data_ready` held 0 -> second delivery pulses `overrun_err`, `data_out==8'h49`, `data_valid` stays 1.
- 3-cycle low glitch on idle `rx` -> returns to IDLE, no `data_valid`, no error pulses.
- Stop bit driven 0, line held low 40 cycles -> `frame_err` single pulse, no `data_valid`, `busy` high until `rx` returns high.
- With `UART_RX_PARITY_EN`, send 8'h49 with parity bit 0 (wrong, needs 1) -> `parity_err` pulse, byte discarded; correct parity -> delivered.
- Assert `rst_n` low during bit 4 of a frame -> outputs reset immediately; next clean frame 8'hA5 received correctly.
